// File: rtl/fp16_mul_arbiter_pkg.sv
// mamba2_fp_pkg: shared FP16 datapath constants and the multiplier tag-pipe entry.
package mamba2_fp_pkg;
  localparam int DW = 16;
  localparam int M_LAT = 6;
  localparam int A_LAT = 4;
  localparam int TAG_W = 8;
  localparam int ID_W_MAX = 3;
  typedef struct packed {
    logic valid;
    logic [ID_W_MAX-1:0] id;
    logic [TAG_W-1:0] tag;
  } tag_ent_t;
endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// fp16_mul_arbiter_if: requester, response and multiplier signals of the shared FP16 multiplier.
interface fp16_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW = mamba2_fp_pkg::DW,
  parameter int TAG_W = mamba2_fp_pkg::TAG_W
);
  logic [N_REQ-1:0] req_valid, req_ready, rsp_valid;
  logic [N_REQ*DW-1:0] req_a_flat, req_b_flat;
  logic [N_REQ*TAG_W-1:0] req_tag_flat;
  logic [DW-1:0] mul_a, mul_b, mul_result, rsp_data;
  logic mul_valid_in, mul_valid_out;
  logic [TAG_W-1:0] rsp_tag;
  modport slave (
    input req_valid, req_a_flat, req_b_flat, req_tag_flat, mul_result, mul_valid_out,
    output req_ready, mul_a, mul_b, mul_valid_in, rsp_valid, rsp_data, rsp_tag
  );
  modport master (
    output req_valid, req_a_flat, req_b_flat, req_tag_flat, mul_result, mul_valid_out,
    input req_ready, mul_a, mul_b, mul_valid_in, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/fp16_mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant with a registered rotating pointer.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input logic clk,
  input logic rst_n,
  input logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id
);
  logic [W-1:0] ptr;
  logic [N-1:0] masked, pick;
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) masked[i] = req[i] && (W'(i) >= ptr);
    pick = |masked ? masked : req;
    gnt = '0;
    gnt_id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (pick[i]) begin
        gnt = '0;
        gnt[i] = 1'b1;
        gnt_id = W'(i);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (|req) ptr <= (gnt_id == W'(N - 1)) ? '0 : gnt_id + W'(1);
endmodule

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin sharing of one pipelined FP16 multiplier among N_REQ requesters,
// with a latency-aligned tag pipe that routes each product back to its originator.
module fp16_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW = mamba2_fp_pkg::DW,
  parameter int TAG_W = mamba2_fp_pkg::TAG_W,
  parameter int M_LAT = mamba2_fp_pkg::M_LAT,
  localparam int ID_W = $clog2(N_REQ)
) (
  input logic clk,
  input logic rst_n,
  fp16_mul_arbiter_if.slave bus,
  output logic busy,
  output logic err
);
  import mamba2_fp_pkg::*;
  localparam int PW = mamba2_fp_pkg::TAG_W;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic [DW-1:0] sel_a, sel_b;
  logic [TAG_W-1:0] sel_tag;
  tag_ent_t iss, head;
  tag_ent_t pipe [M_LAT];
  logic pipe_busy, fire;

  rr_arbiter #(.N(N_REQ)) u_arb (.clk, .rst_n, .req(bus.req_valid), .gnt, .gnt_id);

  assign bus.req_ready = rst_n ? gnt : '0;
  assign bus.mul_valid_in = iss.valid;
  assign head = pipe[M_LAT-1];
  assign fire = bus.mul_valid_out & head.valid;
  assign busy = pipe_busy | iss.valid | (|bus.rsp_valid);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_tag = '0;
    pipe_busy = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) begin
        sel_a = bus.req_a_flat[i*DW +: DW];
        sel_b = bus.req_b_flat[i*DW +: DW];
        sel_tag = bus.req_tag_flat[i*TAG_W +: TAG_W];
      end
    for (int i = 0; i < M_LAT; i++) pipe_busy = pipe_busy | pipe[i].valid;
  end

  // The issue register feeds stage 0, so the head lines up with mul_valid_out.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      iss <= '0;
      bus.mul_a <= '0;
      bus.mul_b <= '0;
      for (int i = 0; i < M_LAT; i++) pipe[i] <= '0;
    end else begin
      iss <= '{valid: |gnt, id: ID_W_MAX'(gnt_id), tag: PW'(sel_tag)};
      if (|gnt) begin
        bus.mul_a <= sel_a;
        bus.mul_b <= sel_b;
      end
      pipe[0] <= iss;
      for (int i = 1; i < M_LAT; i++) pipe[i] <= pipe[i-1];
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_data <= '0;
      bus.rsp_tag <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) bus.rsp_valid[i] <= fire && (head.id == ID_W_MAX'(i));
      if (fire) begin
        bus.rsp_data <= bus.mul_result;
        bus.rsp_tag <= TAG_W'(head.tag);
      end
      if (bus.mul_valid_out != head.valid) err <= 1'b1;
    end
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: random and directed stimulus against a queue-based reference model,
// with a behavioural FP16 multiplier of configurable latency standing in for the real one.
module tb_fp16_mul_arbiter;
  localparam int N = 4, W = 16, T = 8, L = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy, err;
  int tests = 0, fails = 0, cyc = 0, mlat = L;
  bit rsp_chk = 1, quiet = 1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp16_mul_arbiter_if #(.N_REQ(N), .DW(W), .TAG_W(T)) bus ();
  fp16_mul_arbiter #(.N_REQ(N), .DW(W), .TAG_W(T), .M_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err(err)
  );

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    int e;
    logic [21:0] p;
    p = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      e++;
      p = p >> 1;
    end
    return {a[15] ^ b[15], e[4:0], p[19:10]};
  endfunction

  // External multiplier: never reset by the block under test.
  logic [7:0] mv = '0;
  logic [15:0] md [8];
  always @(posedge clk) begin
    mv <= {mv[6:0], bus.mul_valid_in};
    md[0] <= fp16_mul(bus.mul_a, bus.mul_b);
    for (int i = 1; i < 8; i++) md[i] <= md[i-1];
  end
  assign bus.mul_valid_out = mv[mlat-1];
  assign bus.mul_result = md[mlat-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh2id(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    int due;
    int id;
    logic [15:0] a, b;
    logic [7:0] tag;
  } op_t;
  op_t q[$];
  int rsp_ids[$], rsp_cyc[$];
  logic [7:0] rsp_tags[$];
  int m_g;
  bit vi_exp = 0;
  logic [15:0] a_exp, b_exp;

  // Reference model: rotating-priority grant, issue one cycle later, response M_LAT+2 after grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      vi_exp = 0;
      m_g = 0;
    end else begin
      if (|bus.rsp_valid) begin
        rsp_ids.push_back(oh2id(bus.rsp_valid));
        rsp_tags.push_back(bus.rsp_tag);
        rsp_cyc.push_back(cyc);
      end
      chk("issue_valid", 32'(bus.mul_valid_in), 32'(vi_exp));
      if (vi_exp) begin
        chk("issue_a", 32'(bus.mul_a), 32'(a_exp));
        chk("issue_b", 32'(bus.mul_b), 32'(b_exp));
      end
      if (rsp_chk) begin
        chk("busy", 32'(busy), 32'(q.size() != 0));
        if (q.size() != 0 && q[0].due == cyc) begin
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << q[0].id);
          chk("rsp_data", 32'(bus.rsp_data), 32'(fp16_mul(q[0].a, q[0].b)));
          chk("rsp_tag", 32'(bus.rsp_tag), 32'(q[0].tag));
          void'(q.pop_front());
        end else chk("rsp_idle", 32'(bus.rsp_valid), 0);
      end
      if (quiet) chk("err_clear", 32'(err), 0);
      begin
        int g;
        g = -1;
        for (int k = 0; k < N; k++) if (g < 0 && bus.req_valid[(m_g + k) % N]) g = (m_g + k) % N;
        chk("grant", 32'(bus.req_ready), (g < 0) ? 0 : 32'(1) << g);
        vi_exp = (g >= 0);
        if (g >= 0) begin
          a_exp = bus.req_a_flat[g*W +: W];
          b_exp = bus.req_b_flat[g*W +: W];
          q.push_back(op_t'{cyc + L + 2, g, a_exp, b_exp, bus.req_tag_flat[g*T +: T]});
          m_g = (g + 1) % N;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [7:0] tg);
    bus.req_a_flat[i*W +: W] = a;
    bus.req_b_flat[i*W +: W] = b;
    bus.req_tag_flat[i*T +: T] = tg;
  endtask

  function automatic logic [15:0] rnd_fp();
    return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    rsp_ids.delete();
    rsp_tags.delete();
    rsp_cyc.delete();
  endtask

  initial begin
    int t0, n, e_cyc;
    bus.req_valid = '1;
    bus.req_a_flat = '0;
    bus.req_b_flat = '0;
    bus.req_tag_flat = '0;
    #1 rst_n = 1'b0;
    step();
    step();
    chk("pin_mul_1x2", 32'(fp16_mul(16'h3C00, 16'h4000)), 32'h4000);
    chk("pin_mul_1p5sq", 32'(fp16_mul(16'h3E00, 16'h3E00)), 32'h4080);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_mul_vi", 32'(bus.mul_valid_in), 0);
    chk("rst_mul_a", 32'(bus.mul_a), 0);
    chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_tag}), 0);
    chk("rst_busy_err", 32'({busy, err}), 0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    step();
    // single request from requester 2
    set_req(2, 16'h3C00, 16'h4000, 8'h5A);
    bus.req_valid = 4'b0100;
    t0 = cyc;
    step();
    bus.req_valid = '0;
    chk("single_issue", 32'(bus.mul_valid_in), 1);
    n = 0;
    while (bus.rsp_valid == '0 && n < 20) begin
      step();
      n++;
    end
    chk("single_latency", 32'(cyc - t0), 32'(L + 2));
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
    chk("single_rsp_data", 32'(bus.rsp_data), 32'h4000);
    chk("single_rsp_tag", 32'(bus.rsp_tag), 32'h5A);
    step();
    chk("single_busy_low", 32'(busy), 0);
    // all requesters held valid from ptr 0
    pulse_reset();
    clear_log();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp(), 8'(k * 16 + i));
      bus.req_valid = '1;
      #1;
      chk("rr_order", 32'(bus.req_ready), 32'(1) << (k % N));
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    repeat (L + 4) step();
    chk("rr_rsp_count", 32'(rsp_ids.size()), 8);
    for (int k = 0; k < rsp_ids.size(); k++) begin
      chk("rr_rsp_id", 32'(rsp_ids[k]), 32'(k % N));
      chk("rr_rsp_tag", 32'(rsp_tags[k]), 32'(k * 16 + k % N));
    end
    // back-to-back single requester
    clear_log();
    for (int k = 0; k < 16; k++) begin
      set_req(1, rnd_fp(), rnd_fp(), 8'(8'hA0 + k));
      bus.req_valid = 4'b0010;
      #1;
      chk("stream_grant", 32'(bus.req_ready), 32'b0010);
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    repeat (L + 4) step();
    chk("stream_count", 32'(rsp_ids.size()), 16);
    if (rsp_ids.size() == 16) begin
      chk("stream_back_to_back", 32'(rsp_cyc[15] - rsp_cyc[0]), 15);
      for (int k = 0; k < 16; k++) begin
        chk("stream_id", 32'(rsp_ids[k]), 1);
        chk("stream_tag", 32'(rsp_tags[k]), 32'(8'hA0 + k));
      end
    end
    // randomized traffic
    repeat (300) begin
      for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp(), 8'($urandom));
      bus.req_valid = 4'($urandom);
      step();
    end
    bus.req_valid = '0;
    repeat (L + 4) step();
    // reset two cycles after issuing three ops
    for (int k = 0; k < 3; k++) begin
      set_req(0, rnd_fp(), rnd_fp(), 8'(k));
      bus.req_valid = 4'b0001;
      step();
    end
    bus.req_valid = '0;
    step();
    step();
    chk("pre_reset_busy", 32'(busy), 1);
    bus.req_valid = '1;
    #2;
    quiet = 0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(bus.req_ready), 0);
    chk("async_rst_issue", 32'({bus.mul_valid_in, bus.mul_a, bus.mul_b}), 0);
    chk("async_rst_rsp", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_tag}), 0);
    chk("async_rst_busy_err", 32'({busy, err}), 0);
    step();
    bus.req_valid = '0;
    rst_n = 1'b1;
    clear_log();
    repeat (8) step();
    chk("stale_err", 32'(err), 1);
    chk("stale_no_rsp", 32'(rsp_ids.size()), 0);
    // multiplier latency shorter than the tag pipe
    pulse_reset();
    chk("err_cleared_by_reset", 32'(err), 0);
    rsp_chk = 0;
    mlat = 5;
    clear_log();
    set_req(3, 16'h3C00, 16'h3E00, 8'hC3);
    bus.req_valid = 4'b1000;
    t0 = cyc;
    step();
    bus.req_valid = '0;
    e_cyc = -1;
    repeat (14) begin
      if (err && e_cyc < 0) e_cyc = cyc;
      step();
    end
    chk("fault_err_cycle", 32'(e_cyc - t0), 7);
    chk("fault_err_sticky", 32'(err), 1);
    chk("fault_no_rsp", 32'(rsp_ids.size()), 0);
    rst_n = 1'b0;
    #1;
    chk("fault_err_reset", 32'(err), 0);
    step();
    rst_n = 1'b1;
    mlat = L;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
